// File: rtl/mc_control_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// master is the controller side, slave is the datapath side.
interface mc_control_if #(
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 32
);
    logic [6:0]          op_code;
    logic [2:0]          funct3;
    logic                funct7_5;
    logic                zero;
    logic                lt;
    logic                ltu;
    logic                imem_ready;
    logic                dmem_ready;
    logic                imem_req;
    logic                ir_write;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic [1:0]          alu_src_a;
    logic                alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          mem_to_reg;
    logic                reg_write;
    logic                dmem_req;
    logic                dmem_we;
    logic                illegal;
    logic                bus_err;
    logic [2:0]          state;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  op_code, funct3, funct7_5, zero, lt, ltu, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
               mem_to_reg, reg_write, dmem_req, dmem_we, illegal, bus_err, state, retired
    );

    modport slave (
        output op_code, funct3, funct7_5, zero, lt, ltu, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
               mem_to_reg, reg_write, dmem_req, dmem_we, illegal, bus_err, state, retired
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/writeback with
// handshake timeouts, sticky trap causes and a retired-instruction counter.
module mc_control #(
    parameter int ALU_OP_W = 4,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    mc_control_if.master bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0]  retired_q;
    logic              illegal_q, illegal_d;
    logic              busErr_q, busErr_d;
    logic              retire;
    logic              legal;
    logic              taken;
    logic [3:0]        aluOp;
    logic              isLoad, isStore, isBranch, isLui, isAuipc, isJal, isJalr, isImm;

    assign isLoad   = (bus.op_code == OP_LOAD);
    assign isStore  = (bus.op_code == OP_STORE);
    assign isBranch = (bus.op_code == OP_BRANCH);
    assign isLui    = (bus.op_code == OP_LUI);
    assign isAuipc  = (bus.op_code == OP_AUIPC);
    assign isJal    = (bus.op_code == OP_JAL);
    assign isJalr   = (bus.op_code == OP_JALR);
    assign isImm    = (bus.op_code == OP_IMM);

    // Branch funct3 010/011 have no RV32I meaning and are rejected with the bad opcodes.
    always_comb begin
        legal = 1'b0;
        case (bus.op_code)
            OP_R, OP_IMM, OP_LOAD, OP_STORE,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: legal = 1'b1;
            OP_BRANCH:                         legal = (bus.funct3[2:1] != 2'b01);
            default:                           legal = 1'b0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (bus.funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = ~bus.zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = ~bus.lt;
            3'b110:  taken = bus.ltu;
            3'b111:  taken = ~bus.ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        aluOp = 4'b0000;
        case (bus.op_code)
            OP_R:      aluOp = {bus.funct7_5, bus.funct3};
            OP_IMM:    aluOp = {bus.funct7_5 & (bus.funct3 == 3'b101), bus.funct3};
            OP_BRANCH: aluOp = 4'b1000;
            default:   aluOp = 4'b0000;
        endcase
    end

    // Outputs are gated off while rst is high so an aborted MEM/WB cannot pulse a write.
    always_comb begin
        state_d        = state_q;
        waitCnt_d      = '0;
        illegal_d      = illegal_q;
        busErr_d       = busErr_q;
        retire         = 1'b0;
        bus.imem_req   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 1'b0;
        bus.alu_op     = '0;
        bus.mem_to_reg = 2'b00;
        bus.reg_write  = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ready) begin
                        bus.ir_write = 1'b1;
                        state_d      = DECODE;
                    end else if (waitCnt_q == WAIT_LAST) begin
                        busErr_d = 1'b1;
                        state_d  = TRAP;
                    end else begin
                        waitCnt_d = waitCnt_q + 1'b1;
                    end
                end
                DECODE: begin
                    if (legal) begin
                        state_d = EXEC;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = TRAP;
                    end
                end
                EXEC: begin
                    bus.alu_op    = ALU_OP_W'(aluOp);
                    bus.alu_src_b = isImm | isLoad | isStore | isAuipc | isJalr;
                    if (isAuipc) bus.alu_src_a = 2'b01;
                    else if (isLui) bus.alu_src_a = 2'b10;
                    if (isLoad || isStore) begin
                        state_d = MEM;
                    end else if (isBranch) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = taken ? 2'b10 : 2'b00;
                        retire       = 1'b1;
                        state_d      = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
                MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = isStore;
                    if (bus.dmem_ready) begin
                        if (isStore) begin
                            bus.pc_write = 1'b1;
                            retire       = 1'b1;
                            state_d      = FETCH;
                        end else begin
                            state_d = WB;
                        end
                    end else if (waitCnt_q == WAIT_LAST) begin
                        busErr_d = 1'b1;
                        state_d  = TRAP;
                    end else begin
                        waitCnt_d = waitCnt_q + 1'b1;
                    end
                end
                WB: begin
                    bus.reg_write = 1'b1;
                    bus.pc_write  = 1'b1;
                    if (isLoad) bus.mem_to_reg = 2'b11;
                    else if (isLui) bus.mem_to_reg = 2'b01;
                    else if (isJal || isJalr) bus.mem_to_reg = 2'b10;
                    if (isJal) bus.pc_src = 2'b10;
                    else if (isJalr) bus.pc_src = 2'b01;
                    retire  = 1'b1;
                    state_d = FETCH;
                end
                TRAP: state_d = TRAP;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            waitCnt_q <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            busErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            illegal_q <= illegal_d;
            busErr_q  <= busErr_d;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.state   = state_q;
    assign bus.retired = retired_q;
    assign bus.illegal = illegal_q;
    assign bus.bus_err = busErr_q;
endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: table of instructions plus hand-built
// stall, timeout, illegal-opcode and reset sequences, checked cycle by cycle.
module tb_mc_control;
    localparam int ALU_OP_W = 4;
    localparam int TIMEOUT  = 4;
    localparam int CNT_W    = 4;
    localparam int CLS_WB = 0, CLS_LD = 1, CLS_ST = 2, CLS_BR = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mc_control_if #(.ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)) bus ();

    mc_control #(.ALU_OP_W(ALU_OP_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] state;
        logic       imemReq;
        logic       irWrite;
        logic       pcWrite;
        logic [1:0] pcSrc;
        logic [1:0] aluSrcA;
        logic       aluSrcB;
        logic [3:0] aluOp;
        logic [1:0] memToReg;
        logic       regWrite;
        logic       dmemReq;
        logic       dmemWe;
        logic       illegal;
        logic       busErr;
        logic [3:0] retired;
    } outs_t;

    typedef struct {
        string tag;
        logic  imemReady;
        logic  dmemReady;
        outs_t exp;
    } cyc_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f75;
        logic       zero;
        logic       lt;
        logic       ltu;
        int         cls;
        logic [3:0] aluOp;
        logic [1:0] srcA;
        logic       srcB;
        logic [1:0] pcSrc;
        logic [1:0] memToReg;
    } vec_t;

    cyc_t  plan[$];
    outs_t expQ[$];
    string tagQ[$];
    int    checks = 0;
    int    errors = 0;
    logic [3:0] rModel = 4'd0;
    logic  illM = 1'b0;
    logic  busM = 1'b0;
    vec_t  tbl[19];

    function automatic vec_t mkVec(string name, logic [6:0] op, logic [2:0] f3, logic f75,
                                   logic z, logic l, logic lu, int cls, logic [3:0] aop,
                                   logic [1:0] sa, logic sb, logic [1:0] ps, logic [1:0] m2r);
        vec_t v;
        v.name = name; v.op = op; v.f3 = f3; v.f75 = f75; v.zero = z; v.lt = l; v.ltu = lu;
        v.cls = cls; v.aluOp = aop; v.srcA = sa; v.srcB = sb; v.pcSrc = ps; v.memToReg = m2r;
        return v;
    endfunction

    function automatic outs_t baseOut(logic [2:0] st);
        outs_t o = '0;
        o.state   = st;
        o.retired = rModel;
        o.illegal = illM;
        o.busErr  = busM;
        return o;
    endfunction

    function automatic outs_t sampleOuts();
        outs_t a;
        a.state = bus.state; a.imemReq = bus.imem_req; a.irWrite = bus.ir_write;
        a.pcWrite = bus.pc_write; a.pcSrc = bus.pc_src; a.aluSrcA = bus.alu_src_a;
        a.aluSrcB = bus.alu_src_b; a.aluOp = bus.alu_op[3:0]; a.memToReg = bus.mem_to_reg;
        a.regWrite = bus.reg_write; a.dmemReq = bus.dmem_req; a.dmemWe = bus.dmem_we;
        a.illegal = bus.illegal; a.busErr = bus.bus_err; a.retired = bus.retired;
        return a;
    endfunction

    task automatic addCycle(input string tag, input logic ir, input logic dr, input outs_t o);
        cyc_t c;
        c.tag = tag; c.imemReady = ir; c.dmemReady = dr; c.exp = o;
        plan.push_back(c);
    endtask

    task automatic setInstr(input vec_t v);
        bus.op_code = v.op; bus.funct3 = v.f3; bus.funct7_5 = v.f75;
        bus.zero = v.zero; bus.lt = v.lt; bus.ltu = v.ltu;
    endtask

    task automatic buildFront(input vec_t v, input int fetchStall);
        outs_t o;
        for (int i = 0; i < fetchStall; i++) begin
            o = baseOut(3'd0); o.imemReq = 1'b1;
            addCycle({v.name, " fetch-stall"}, 1'b0, 1'b0, o);
        end
        o = baseOut(3'd0); o.imemReq = 1'b1; o.irWrite = 1'b1;
        addCycle({v.name, " fetch"}, 1'b1, 1'b0, o);
        o = baseOut(3'd1);
        addCycle({v.name, " decode"}, 1'b0, 1'b0, o);
    endtask

    task automatic buildExec(input vec_t v);
        outs_t o = baseOut(3'd2);
        o.aluOp = v.aluOp; o.aluSrcA = v.srcA; o.aluSrcB = v.srcB;
        if (v.cls == CLS_BR) begin
            o.pcWrite = 1'b1; o.pcSrc = v.pcSrc;
        end
        addCycle({v.name, " exec"}, 1'b0, 1'b0, o);
        if (v.cls == CLS_BR) rModel = rModel + 1'b1;
    endtask

    task automatic buildMem(input vec_t v, input int stall, input bit complete);
        outs_t o;
        for (int i = 0; i < stall; i++) begin
            o = baseOut(3'd3); o.dmemReq = 1'b1; o.dmemWe = (v.cls == CLS_ST);
            addCycle({v.name, " mem-stall"}, 1'b0, 1'b0, o);
        end
        if (complete) begin
            o = baseOut(3'd3); o.dmemReq = 1'b1; o.dmemWe = (v.cls == CLS_ST);
            o.pcWrite = (v.cls == CLS_ST);
            addCycle({v.name, " mem"}, 1'b0, 1'b1, o);
            if (v.cls == CLS_ST) rModel = rModel + 1'b1;
        end
    endtask

    task automatic buildWb(input vec_t v);
        outs_t o = baseOut(3'd4);
        o.regWrite = 1'b1; o.pcWrite = 1'b1; o.pcSrc = v.pcSrc; o.memToReg = v.memToReg;
        addCycle({v.name, " wb"}, 1'b0, 1'b0, o);
        rModel = rModel + 1'b1;
    endtask

    task automatic buildInstr(input vec_t v, input int fetchStall, input int memStall);
        buildFront(v, fetchStall);
        buildExec(v);
        if (v.cls == CLS_LD || v.cls == CLS_ST) buildMem(v, memStall, 1'b1);
        if (v.cls == CLS_WB || v.cls == CLS_LD) buildWb(v);
    endtask

    task automatic addTrap(input int n);
        for (int i = 0; i < n; i++) addCycle("trap", 1'b1, 1'b1, baseOut(3'd7));
    endtask

    task automatic applyStimulus(input cyc_t c);
        bus.imem_ready = c.imemReady;
        bus.dmem_ready = c.dmemReady;
        expQ.push_back(c.exp);
        tagQ.push_back(c.tag);
    endtask

    task automatic checkOutput(input int dly);
        outs_t act, exp;
        string tag;
        #(dly);
        act = sampleOuts();
        exp = expQ.pop_front();
        tag = tagQ.pop_front();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Each cycle is driven just after the rising edge and checked mid-cycle.
    task automatic playPlan();
        while (plan.size() > 0) begin
            applyStimulus(plan.pop_front());
            checkOutput(2);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input string tag);
        cyc_t c;
        #2;
        rst = 1'b1;
        rModel = 4'd0; illM = 1'b0; busM = 1'b0;
        c.tag = tag; c.imemReady = 1'b1; c.dmemReady = 1'b1; c.exp = baseOut(3'd0);
        applyStimulus(c);
        checkOutput(1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        tbl[0]  = mkVec("add",   7'b0110011, 3'b000, 0, 0, 0, 0, CLS_WB, 4'b0000, 2'b00, 0, 2'b00, 2'b00);
        tbl[1]  = mkVec("sub",   7'b0110011, 3'b000, 1, 0, 0, 0, CLS_WB, 4'b1000, 2'b00, 0, 2'b00, 2'b00);
        tbl[2]  = mkVec("sra",   7'b0110011, 3'b101, 1, 0, 0, 0, CLS_WB, 4'b1101, 2'b00, 0, 2'b00, 2'b00);
        tbl[3]  = mkVec("addi",  7'b0010011, 3'b000, 1, 0, 0, 0, CLS_WB, 4'b0000, 2'b00, 1, 2'b00, 2'b00);
        tbl[4]  = mkVec("srai",  7'b0010011, 3'b101, 1, 0, 0, 0, CLS_WB, 4'b1101, 2'b00, 1, 2'b00, 2'b00);
        tbl[5]  = mkVec("slti",  7'b0010011, 3'b010, 0, 0, 0, 0, CLS_WB, 4'b0010, 2'b00, 1, 2'b00, 2'b00);
        tbl[6]  = mkVec("lui",   7'b0110111, 3'b000, 0, 0, 0, 0, CLS_WB, 4'b0000, 2'b10, 0, 2'b00, 2'b01);
        tbl[7]  = mkVec("auipc", 7'b0010111, 3'b000, 0, 0, 0, 0, CLS_WB, 4'b0000, 2'b01, 1, 2'b00, 2'b00);
        tbl[8]  = mkVec("jal",   7'b1101111, 3'b000, 0, 0, 0, 0, CLS_WB, 4'b0000, 2'b00, 0, 2'b10, 2'b10);
        tbl[9]  = mkVec("jalr",  7'b1100111, 3'b000, 0, 0, 0, 0, CLS_WB, 4'b0000, 2'b00, 1, 2'b01, 2'b10);
        tbl[10] = mkVec("lw",    7'b0000011, 3'b010, 0, 0, 0, 0, CLS_LD, 4'b0000, 2'b00, 1, 2'b00, 2'b11);
        tbl[11] = mkVec("sw",    7'b0100011, 3'b010, 0, 0, 0, 0, CLS_ST, 4'b0000, 2'b00, 1, 2'b00, 2'b00);
        tbl[12] = mkVec("beq-t", 7'b1100011, 3'b000, 0, 1, 0, 0, CLS_BR, 4'b1000, 2'b00, 0, 2'b10, 2'b00);
        tbl[13] = mkVec("bne-t", 7'b1100011, 3'b001, 0, 0, 0, 0, CLS_BR, 4'b1000, 2'b00, 0, 2'b10, 2'b00);
        tbl[14] = mkVec("bne-n", 7'b1100011, 3'b001, 0, 1, 0, 0, CLS_BR, 4'b1000, 2'b00, 0, 2'b00, 2'b00);
        tbl[15] = mkVec("blt-t", 7'b1100011, 3'b100, 0, 0, 1, 0, CLS_BR, 4'b1000, 2'b00, 0, 2'b10, 2'b00);
        tbl[16] = mkVec("bge-n", 7'b1100011, 3'b101, 0, 0, 1, 0, CLS_BR, 4'b1000, 2'b00, 0, 2'b00, 2'b00);
        tbl[17] = mkVec("bltu-n",7'b1100011, 3'b110, 0, 0, 0, 0, CLS_BR, 4'b1000, 2'b00, 0, 2'b00, 2'b00);
        tbl[18] = mkVec("bgeu-t",7'b1100011, 3'b111, 0, 0, 0, 0, CLS_BR, 4'b1000, 2'b00, 0, 2'b10, 2'b00);

        bus.op_code = 7'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0;
        bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;

        // Reset held at start: everything idle, then release just after an edge.
        #1 rst = 1'b1;
        addCycle("reset", 1'b0, 1'b0, baseOut(3'd0));
        applyStimulus(plan.pop_front());
        checkOutput(2);
        @(posedge clk);
        #1 rst = 1'b0;

        // 19 retiring instructions with a 4-bit counter exercise the wrap.
        for (int i = 0; i < 19; i++) begin
            setInstr(tbl[i]);
            buildInstr(tbl[i], 0, 0);
            playPlan();
        end

        // Load with ready arriving on the last allowed cycle of both handshakes.
        setInstr(tbl[10]);
        buildInstr(tbl[10], TIMEOUT - 1, TIMEOUT - 1);
        playPlan();

        // Store whose data handshake never completes.
        setInstr(tbl[11]);
        buildFront(tbl[11], 0);
        buildExec(tbl[11]);
        buildMem(tbl[11], TIMEOUT, 1'b0);
        busM = 1'b1;
        addTrap(2);
        playPlan();
        doReset("reset in trap (bus_err)");

        v = mkVec("bad-op", 7'b1111111, 3'b000, 0, 0, 0, 0, CLS_WB, 4'b0000, 2'b00, 0, 2'b00, 2'b00);
        setInstr(tbl[0]);
        buildInstr(tbl[0], 0, 0);
        playPlan();
        setInstr(v);
        buildFront(v, 0);
        illM = 1'b1;
        addTrap(2);
        playPlan();
        doReset("reset in trap (illegal op)");

        v = mkVec("bad-br", 7'b1100011, 3'b011, 0, 0, 0, 0, CLS_BR, 4'b1000, 2'b00, 0, 2'b00, 2'b00);
        setInstr(v);
        buildFront(v, 0);
        illM = 1'b1;
        addTrap(2);
        playPlan();
        doReset("reset in trap (illegal branch)");

        // Reset while a load is stalled in MEM must abort with no write pulses.
        setInstr(tbl[3]);
        buildInstr(tbl[3], 0, 0);
        playPlan();
        setInstr(tbl[10]);
        buildFront(tbl[10], 0);
        buildExec(tbl[10]);
        buildMem(tbl[10], 2, 1'b0);
        playPlan();
        doReset("reset mid-mem");

        setInstr(tbl[0]);
        buildInstr(tbl[0], 0, 0);
        playPlan();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
